// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, widths and hashing for the branch prediction unit.
//   idx_width    - clog2 of a table depth
//   tag_width    - BTB tag width for a given PC width and BTB depth
//   ctr_rst_val  - weakly-not-taken counter value for a counter width
//   bht_index    - direction-table index (bimodal or gshare), used by both
//                  the lookup and the update paths
//   btb_entry_t  - BTB entry {valid, tag, target}, fields sized for the
//                  widest supported PC; users zero-extend on write and slice
//                  on read
package bpu_pkg;

  localparam int unsigned BPU_MAX_W     = 64;
  localparam int unsigned BPU_MAX_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [BPU_MAX_W-1:0] tag;
    logic [BPU_MAX_W-1:0] target;
  } btb_entry_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned tag_width(input int unsigned pc_w,
                                            input int unsigned btb_depth);
    return pc_w - $clog2(btb_depth) - 2;
  endfunction

  // {1'b0, {ctr_w-1{1'b1}}}, returned in the widest supported counter width
  function automatic logic [3:0] ctr_rst_val(input int unsigned ctr_w);
    return 4'((1 << (ctr_w - 1)) - 1);
  endfunction

  // bidx = pc[idx_w+1:2]; the low ghr_w bits are XORed with history.
  // ghr_w == 0 masks the history away entirely (bimodal).
  function automatic logic [BPU_MAX_IDX_W-1:0] bht_index(
    input logic [BPU_MAX_W-1:0]     pc,
    input logic [BPU_MAX_IDX_W-1:0] ghr,
    input int unsigned              idx_w,
    input int unsigned              ghr_w
  );
    logic [BPU_MAX_IDX_W-1:0] idx_mask;
    logic [BPU_MAX_IDX_W-1:0] ghr_mask;
    logic [BPU_MAX_IDX_W-1:0] bidx;
    idx_mask = (BPU_MAX_IDX_W'(1) << idx_w) - BPU_MAX_IDX_W'(1);
    ghr_mask = (BPU_MAX_IDX_W'(1) << ghr_w) - BPU_MAX_IDX_W'(1);
    bidx     = BPU_MAX_IDX_W'(pc >> 2) & idx_mask;
    return bidx ^ (ghr & ghr_mask);
  endfunction

endpackage

// File: rtl/bpu_if.sv
// bpu_if: fetch-lookup / execute-update bundle of the branch predictor.
//   lkp_pc, pred_take, pred_hit, pred_target - fetch-side lookup
//   upd_valid, upd_pc, upd_taken, upd_target - execute-side resolution
//   ghr_out                                   - current global history (debug)
// master: the core side (drives lookup PC and updates); slave: the bpu.
interface bpu_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned GHR_W = 0
);
  localparam int unsigned GHR_OW = (GHR_W == 0) ? 1 : GHR_W;

  logic [PC_W-1:0]   lkp_pc;
  logic              pred_take;
  logic              pred_hit;
  logic [PC_W-1:0]   pred_target;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic [GHR_OW-1:0] ghr_out;

  modport master (
    output lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_take, pred_hit, pred_target, ghr_out
  );

  modport slave (
    input  lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_take, pred_hit, pred_target, ghr_out
  );
endinterface

// File: rtl/bpu_sat_ctr.sv
// sat_ctr: W-bit saturating up/down counter.
//   clk, rst_n - clock, asynchronous active-low reset (to RST_VAL)
//   en         - step this cycle
//   up         - 1: increment (saturate at all-ones), 0: decrement (saturate at 0)
//   val        - current count
module sat_ctr #(
  parameter int unsigned   W       = 2,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] val
);

  logic [W-1:0] val_d;

  always_comb begin
    val_d = val;
    if (en) begin
      if (up) begin
        if (val != '1) val_d = val + W'(1);
      end else begin
        if (val != '0) val_d = val - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val <= RST_VAL;
    else        val <= val_d;
  end

endmodule

// File: rtl/bpu.sv
// bpu: branch prediction unit - saturating direction counters indexed by PC
// (bimodal, GHR_W == 0) or PC XOR global history (gshare), plus an optional
// direct-mapped branch target buffer.
//   clk      - core clock
//   pc_rst_n - asynchronous active-low reset
//   bus      - bpu_if slave: combinational lookup (lkp_pc -> pred_take,
//              pred_hit, pred_target), resolved-branch update (upd_*),
//              ghr_out debug history
// Build option: define BPU_BTB_EN to instantiate the BTB; otherwise
// pred_hit/pred_target are tied to 0 and upd_target is ignored.
module bpu
  import bpu_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned GHR_W     = 0,
  parameter int unsigned BTB_DEPTH = 16
) (
  input logic  clk,
  input logic  pc_rst_n,
  bpu_if.slave bus
);

  localparam int unsigned      IDX_W   = idx_width(BHT_DEPTH);
  localparam int unsigned      GHR_OW  = (GHR_W == 0) ? 1 : GHR_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst_val(CTR_W));

  logic [GHR_OW-1:0] ghr_q;
  logic [IDX_W-1:0]  lkp_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [CTR_W-1:0]  ctr_val [BHT_DEPTH];

  // Global history: non-speculative, advanced only by resolved branches
  if (GHR_W == 0) begin : g_bimodal
    assign ghr_q = '0;
  end else begin : g_gshare
    always_ff @(posedge clk or negedge pc_rst_n) begin
      if (!pc_rst_n)          ghr_q <= '0;
      else if (bus.upd_valid) ghr_q <= GHR_OW'({ghr_q, bus.upd_taken});
    end
  end

  assign bus.ghr_out = ghr_q;

  assign lkp_idx = IDX_W'(bht_index(BPU_MAX_W'(bus.lkp_pc),
                                    BPU_MAX_IDX_W'(ghr_q), IDX_W, GHR_W));
  assign upd_idx = IDX_W'(bht_index(BPU_MAX_W'(bus.upd_pc),
                                    BPU_MAX_IDX_W'(ghr_q), IDX_W, GHR_W));

  for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_ctr
    sat_ctr #(
      .W       (CTR_W),
      .RST_VAL (CTR_RST)
    ) u_ctr (
      .clk   (clk),
      .rst_n (pc_rst_n),
      .en    (bus.upd_valid && (upd_idx == IDX_W'(i))),
      .up    (bus.upd_taken),
      .val   (ctr_val[i])
    );
  end

  // Reads the registered counter: a same-cycle update is not bypassed
  assign bus.pred_take = ctr_val[lkp_idx][CTR_W-1];

`ifdef BPU_BTB_EN
  localparam int unsigned BTB_IDX_W = idx_width(BTB_DEPTH);
  localparam int unsigned TAG_W     = tag_width(PC_W, BTB_DEPTH);

  btb_entry_t            btb_q [BTB_DEPTH];
  btb_entry_t            lkp_entry;
  logic [BTB_IDX_W-1:0]  lkp_bidx;
  logic [BTB_IDX_W-1:0]  upd_bidx;
  logic [TAG_W-1:0]      lkp_tag;
  logic [TAG_W-1:0]      upd_tag;
  logic                  btb_hit;
  logic                  unused_btb_bits;

  assign lkp_bidx = bus.lkp_pc[BTB_IDX_W+1:2];
  assign upd_bidx = bus.upd_pc[BTB_IDX_W+1:2];
  assign lkp_tag  = bus.lkp_pc[PC_W-1:BTB_IDX_W+2];
  assign upd_tag  = bus.upd_pc[PC_W-1:BTB_IDX_W+2];

  // Only taken branches allocate; not-taken updates leave the entry alone
  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) btb_q[i] <= '0;
    end else if (bus.upd_valid && bus.upd_taken) begin
      btb_q[upd_bidx] <= '{valid:  1'b1,
                           tag:    BPU_MAX_W'(upd_tag),
                           target: BPU_MAX_W'(bus.upd_target)};
    end
  end

  assign lkp_entry       = btb_q[lkp_bidx];
  assign btb_hit         = lkp_entry.valid && (lkp_entry.tag == BPU_MAX_W'(lkp_tag));
  assign bus.pred_hit    = btb_hit;
  assign bus.pred_target = btb_hit ? lkp_entry.target[PC_W-1:0] : '0;
  assign unused_btb_bits = ^lkp_entry.target;
`else
  logic unused_upd_target;

  assign bus.pred_hit    = 1'b0;
  assign bus.pred_target = '0;
  assign unused_upd_target = ^bus.upd_target;
`endif

endmodule

// File: tb/tb_bpu.sv
module tb_bpu;

`ifdef BPU_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  bpu_if #(.PC_W(32), .GHR_W(0)) bim_if ();
  bpu_if #(.PC_W(32), .GHR_W(4)) gsh_if ();

  bpu #(
    .PC_W(32), .BHT_DEPTH(64), .CTR_W(2), .GHR_W(0), .BTB_DEPTH(16)
  ) u_bim (
    .clk(clk), .pc_rst_n(rst_n), .bus(bim_if.slave)
  );

  bpu #(
    .PC_W(32), .BHT_DEPTH(64), .CTR_W(2), .GHR_W(4), .BTB_DEPTH(16)
  ) u_gsh (
    .clk(clk), .pc_rst_n(rst_n), .bus(gsh_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bim_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    bim_if.upd_valid  = 1'b1;
    bim_if.upd_pc     = pc;
    bim_if.upd_taken  = taken;
    bim_if.upd_target = tgt;
    @(posedge clk);
    #1 bim_if.upd_valid = 1'b0;
  endtask

  task automatic gsh_upd(input logic [31:0] pc, input logic taken);
    @(negedge clk);
    gsh_if.upd_valid  = 1'b1;
    gsh_if.upd_pc     = pc;
    gsh_if.upd_taken  = taken;
    gsh_if.upd_target = 32'h0;
    @(posedge clk);
    #1 gsh_if.upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bim_if.lkp_pc = 32'h100; bim_if.upd_valid = 1'b0; bim_if.upd_pc = '0;
    bim_if.upd_taken = 1'b0; bim_if.upd_target = '0;
    gsh_if.lkp_pc = 32'h100; gsh_if.upd_valid = 1'b0; gsh_if.upd_pc = '0;
    gsh_if.upd_taken = 1'b0; gsh_if.upd_target = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // reset state
    check("rst_take",   64'(bim_if.pred_take),   64'd0);
    check("rst_hit",    64'(bim_if.pred_hit),    64'd0);
    check("rst_target", 64'(bim_if.pred_target), 64'd0);
    check("rst_ghr",    64'(gsh_if.ghr_out),     64'd0);
    check("rst_gtake",  64'(gsh_if.pred_take),   64'd0);

    // two taken updates at 0x100 -> counter 3
    bim_upd(32'h100, 1'b1, 32'h80);
    bim_upd(32'h100, 1'b1, 32'h80);
    bim_if.lkp_pc = 32'h100; #1;
    check("tt_take",   64'(bim_if.pred_take),   64'd1);
    check("tt_hit",    64'(bim_if.pred_hit),    BTB ? 64'd1 : 64'd0);
    check("tt_target", 64'(bim_if.pred_target), BTB ? 64'h80 : 64'd0);

    // 0x200 aliases the direction counter but not the BTB tag
    bim_if.lkp_pc = 32'h200; #1;
    check("alias_take",   64'(bim_if.pred_take),   64'd1);
    check("alias_hit",    64'(bim_if.pred_hit),    64'd0);
    check("alias_target", 64'(bim_if.pred_target), 64'd0);
    bim_if.lkp_pc = 32'h140; #1;
    check("other_take", 64'(bim_if.pred_take), 64'd0);

    // not-taken update: counter 2, BTB target untouched
    bim_upd(32'h100, 1'b0, 32'h44);
    bim_if.lkp_pc = 32'h100; #1;
    check("nt_take",   64'(bim_if.pred_take),   64'd1);
    check("nt_target", 64'(bim_if.pred_target), BTB ? 64'h80 : 64'd0);

    // saturation high: 5T -> 3, N -> 2, N -> 1
    repeat (5) bim_upd(32'h100, 1'b1, 32'h80);
    #1 check("sat5_take", 64'(bim_if.pred_take), 64'd1);
    bim_upd(32'h100, 1'b0, 32'h0);
    #1 check("sat_n1_take", 64'(bim_if.pred_take), 64'd1);
    bim_upd(32'h100, 1'b0, 32'h0);
    #1 check("sat_n2_take", 64'(bim_if.pred_take), 64'd0);

    // saturation low: 5N -> 0, T -> 1 (no wrap to 3)
    repeat (5) bim_upd(32'h100, 1'b0, 32'h0);
    #1 check("low5_take", 64'(bim_if.pred_take), 64'd0);
    bim_upd(32'h100, 1'b1, 32'h80);
    #1 check("low_t_take", 64'(bim_if.pred_take), 64'd0);

    // same-cycle lookup and taken update, counter at 1: no bypass
    @(negedge clk);
    bim_if.lkp_pc     = 32'h100;
    bim_if.upd_valid  = 1'b1;
    bim_if.upd_pc     = 32'h100;
    bim_if.upd_taken  = 1'b1;
    bim_if.upd_target = 32'h80;
    #1 check("same_cyc_take", 64'(bim_if.pred_take), 64'd0);
    @(posedge clk);
    #1 bim_if.upd_valid = 1'b0;
    check("next_cyc_take", 64'(bim_if.pred_take), 64'd1);

    // gshare: T,T,N,T steering counter 13 to 3, counter 6 to 2, counter 3 to 0
    gsh_upd(32'h34, 1'b1);   // idx 13 ^ 0000 = 13
    gsh_upd(32'h30, 1'b1);   // idx 12 ^ 0001 = 13
    gsh_upd(32'h200, 1'b0);  // idx  0 ^ 0011 = 3
    gsh_upd(32'h200, 1'b1);  // idx  0 ^ 0110 = 6
    #1 check("g_ghr", 64'(gsh_if.ghr_out), 64'hd);
    gsh_if.lkp_pc = 32'h100; #1;   // 0 ^ 13 = 13
    check("g_100", 64'(gsh_if.pred_take), 64'd1);
    gsh_if.lkp_pc = 32'h34; #1;    // 13 ^ 13 = 0
    check("g_034", 64'(gsh_if.pred_take), 64'd0);
    gsh_if.lkp_pc = 32'h118; #1;   // 6 ^ 13 = 11
    check("g_118", 64'(gsh_if.pred_take), 64'd0);
    gsh_if.lkp_pc = 32'h2c; #1;    // 11 ^ 13 = 6
    check("g_02c", 64'(gsh_if.pred_take), 64'd1);

    // asynchronous reset mid-cycle, with a concurrent update discarded
    gsh_if.lkp_pc = 32'h100;
    bim_if.lkp_pc = 32'h100;
    @(posedge clk);
    #2 check("pre_rst_take", 64'(bim_if.pred_take), 64'd1);
    rst_n = 1'b0;
    bim_if.upd_valid  = 1'b1;
    bim_if.upd_pc     = 32'h100;
    bim_if.upd_taken  = 1'b1;
    bim_if.upd_target = 32'h80;
    #1;
    check("arst_take",   64'(bim_if.pred_take),   64'd0);
    check("arst_hit",    64'(bim_if.pred_hit),    64'd0);
    check("arst_target", 64'(bim_if.pred_target), 64'd0);
    check("arst_gtake",  64'(gsh_if.pred_take),   64'd0);
    check("arst_ghr",    64'(gsh_if.ghr_out),     64'd0);
    @(posedge clk);
    #1 bim_if.upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_take", 64'(bim_if.pred_take), 64'd0);
    check("post_rst_hit", 64'(bim_if.pred_hit), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpu.md
# bpu

Parametrised branch prediction unit for the five-stage core, replacing the fixed single-bit `take` hint in the fetch stage. It holds a table of saturating direction counters, indexed by PC or by gshare (PC XOR global history), plus an optional branch target buffer. Fetch looks up each PC combinationally. Execute writes back the resolved outcome of every conditional branch, so predictions train over time.

## Interface
Parameters:
- `PC_W`, 32, PC width in bits.
- `BHT_DEPTH`, 64, number of direction counters; power of two, at least 4.
- `CTR_W`, 2, counter width; 2 to 4.
- `GHR_W`, 0, global history length; 0 selects bimodal, otherwise gshare; at most log2(`BHT_DEPTH`).
- `BTB_DEPTH`, 16, number of BTB entries; power of two; used only with `BPU_BTB_EN`.

Ports:
- `clk`  in  1  core clock.
- `pc_rst_n`  in  1  asynchronous, active-low reset.
- `lkp_pc`  in  `PC_W`  fetch PC.
- `pred_take`  out  1  predicted taken.
- `pred_hit`  out  1  BTB holds a valid target for `lkp_pc`.
- `pred_target`  out  `PC_W`  predicted target.
- `upd_valid`  in  1  an execute-stage conditional branch resolved this cycle.
- `upd_pc`  in  `PC_W`  PC of that branch.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  `PC_W`  actual taken target.
- `ghr_out`  out  `GHR_W`, minimum 1  current history, for debug.

One clock; reset is asynchronous and active-low.

## Operation
- Index: `IDX_W` = log2(`BHT_DEPTH`). `bidx` = `pc[IDX_W+1:2]`. In gshare mode the low `GHR_W` bits of `bidx` are XORed with the GHR. Lookup and update use the same function, each on its own PC.
- Direction: `pred_take` equals the MSB of the indexed counter.
- Counter update on `upd_valid`:
  - Taken: increment, saturating at all-ones.
  - Not taken: decrement, saturating at 0.
  - All arithmetic is `CTR_W` bits wide with no wrap.
- GHR update on `upd_valid`: shift left and insert `upd_taken` at bit 0. History is non-speculative; it is never changed at lookup.
- BTB (with `BPU_BTB_EN`): direct-mapped.
  - Index is `pc[log2(BTB_DEPTH)+1:2]`. Tag is the remaining upper bits `pc[PC_W-1:log2(BTB_DEPTH)+2]`.
  - On `upd_valid && upd_taken`, write `{valid=1, tag, upd_target}`. A not-taken update leaves the BTB untouched.
  - `pred_hit` = valid && tag match.
- When the BTB is disabled or misses, `pred_target` is 0 and `pred_hit` is 0. Fetch then redirects only when `pred_take && pred_hit`; otherwise it computes the target after decode.

## Timing
- Lookup is combinational, zero latency from `lkp_pc`.
- Update commits at the rising `clk` edge. It is visible to lookups from the next cycle.
- Same-cycle lookup and update to the same entry: the lookup sees the pre-update value. There is no bypass.
- Reset values:
  - All counters = weakly not-taken (`{1'b0, {CTR_W-1{1'b1}}}`).
  - GHR = 0.
  - All BTB valid bits = 0.
  - Outputs therefore read `pred_take` = 0, `pred_hit` = 0, `pred_target` = 0, `ghr_out` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`. An update presented in the same cycle is discarded.
- Two branches aliasing to one counter share it; this is by design.

## Configuration
- `BPU_BTB_EN` defined: BTB arrays and tag compare are instantiated; `pred_hit` and `pred_target` are live.
- `BPU_BTB_EN` undefined: no BTB storage. `pred_hit` and `pred_target` are tied to 0, and `upd_target` is ignored.

## Structure
- Shared package `bpu_pkg`:
  - Index and tag width functions (clog2-based).
  - The counter reset constant.
  - The BTB entry typedef `{valid, tag, target}`.
- One natural sub-module, `sat_ctr`: a `CTR_W`-bit saturating up/down counter with enable and asynchronous reset, instantiated `BHT_DEPTH` times.
- Index hashing is a package function, shared by the lookup and update paths.

## Test plan
- Reset, then lookup of 0x100 -> `pred_take` = 0, `pred_hit` = 0, `pred_target` = 0.
- Two taken updates at 0x100 (target 0x80), then lookup of 0x100 -> counter = 3, `pred_take` = 1. With BTB: `pred_hit` = 1, `pred_target` = 0x80.
- Saturation: 5 taken updates then 1 not-taken -> counter goes 3 then 2, `pred_take` stays 1. 5 not-taken updates -> counter = 0 with no wrap to 3.
- Lookup and update to 0x100 in the same cycle (counter at 1, update taken) -> `pred_take` = 0 that cycle, 1 the next cycle.
- Gshare with `GHR_W` = 4: the update sequence T, T, N, T gives `ghr_out` = 4'b1101. A subsequent lookup of 0x100 must read counter index `(0x100>>2 & 63) ^ 4'b1101`.
- Assert `pc_rst_n` low asynchronously after training -> all outputs return to 0 before the next `clk` edge.
